block_readout: RTL and testbench

BLOCK_READOUT -- requirements
Module: block_readout

---
 rtl/block_readout.sv | 107 ++++++++++
 tb/tb_block_readout.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_readout.sv
`default_nettype none
// ============================================================================
// Module   : block_readout
// Purpose  : Holds one big-endian result block and drains it word by word as
//            little-endian bus words over a valid/ready interface.
// Revision : 1.0  initial release
// ============================================================================
module block_readout #(
  parameter int WORDS     = 4,
  parameter int WORD_SIZE = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORDS*WORD_SIZE-1:0] block_in,
  input  logic                       block_valid,
  output logic                       block_ready,
  input  logic                       flush,
  output logic [WORD_SIZE-1:0]       rdata,
  output logic                       rvalid,
  input  logic                       rready,
  output logic                       rlast,
  output logic                       busy
);

  localparam int c_WORD_BYTES = WORD_SIZE / 8;
  localparam int c_IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_IDX_W-1:0]         r_idx;
  logic [c_IDX_W-1:0]         w_idx_nxt;
  logic [WORDS*WORD_SIZE-1:0] r_buf;
  logic [WORD_SIZE-1:0]       w_word;
  logic                       w_last;
  logic                       w_capture;

  assign w_last    = (r_idx == c_LAST_IDX);
  assign w_capture = block_valid & block_ready;

  // A new block may enter in the same cycle the final word leaves, so the
  // stream continues without a bubble.
  assign block_ready = ~flush & ((r_state == ST_EMPTY) |
                                 ((r_state == ST_DRAIN) & w_last & rready));
  assign rvalid = (r_state == ST_DRAIN);
  assign busy   = (r_state == ST_DRAIN);
  assign rlast  = (r_state == ST_DRAIN) & w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_idx_nxt   = '0;
    end else if (w_capture) begin
      w_state_nxt = ST_DRAIN;
      w_idx_nxt   = '0;
    end else if ((r_state == ST_DRAIN) && rready) begin
      if (w_last) begin
        w_state_nxt = ST_EMPTY;
        w_idx_nxt   = '0;
      end else begin
        w_idx_nxt = r_idx + c_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_capture) begin
        r_buf <= block_in;
      end
    end
  end

  // Output word k is buffer word WORDS-1-k with its bytes reversed.
  always_comb begin
    w_word = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (r_idx == c_IDX_W'(w)) begin
        w_word = r_buf[(WORDS-1-w)*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (r_state == ST_DRAIN) begin
      for (int b = 0; b < c_WORD_BYTES; b++) begin
        rdata[b*8 +: 8] = w_word[(c_WORD_BYTES-1-b)*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_readout
// Purpose  : Randomized and directed checking of block_readout against a
//            word-queue reference model; WORDS=1/8 instances for the sweep.
// Revision : 1.0  initial release
// ============================================================================
module tb_block_readout;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] block_in = '0;
  logic         block_valid = 1'b0;
  logic         block_ready;
  logic         flush = 1'b0;
  logic [31:0]  rdata;
  logic         rvalid;
  logic         rready = 1'b0;
  logic         rlast;
  logic         busy;

  logic [31:0]  s1_block_in = '0;
  logic         s1_valid = 1'b0;
  logic         s1_ready;
  logic [31:0]  s1_rdata;
  logic         s1_rvalid;
  logic         s1_rlast;
  logic         s1_busy;

  logic [255:0] s8_block_in = '0;
  logic         s8_valid = 1'b0;
  logic         s8_ready;
  logic [31:0]  s8_rdata;
  logic         s8_rvalid;
  logic         s8_rlast;
  logic         s8_busy;

  logic         s_flush = 1'b0;
  logic         s_rready = 1'b1;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  q[$];
  logic [31:0]  obs_rdata;
  logic         obs_ready;
  logic         obs_rvalid;

  always #5 clk = ~clk;

  block_readout #(.WORDS(4), .WORD_SIZE(32)) dut (
    .clk(clk), .rst(rst), .block_in(block_in), .block_valid(block_valid),
    .block_ready(block_ready), .flush(flush), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .rlast(rlast), .busy(busy)
  );

  block_readout #(.WORDS(1), .WORD_SIZE(32)) dut_w1 (
    .clk(clk), .rst(rst), .block_in(s1_block_in), .block_valid(s1_valid),
    .block_ready(s1_ready), .flush(s_flush), .rdata(s1_rdata), .rvalid(s1_rvalid),
    .rready(s_rready), .rlast(s1_rlast), .busy(s1_busy)
  );

  block_readout #(.WORDS(8), .WORD_SIZE(32)) dut_w8 (
    .clk(clk), .rst(rst), .block_in(s8_block_in), .block_valid(s8_valid),
    .block_ready(s8_ready), .flush(s_flush), .rdata(s8_rdata), .rvalid(s8_rvalid),
    .rready(s_rready), .rlast(s8_rlast), .busy(s8_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Word k of the stream: the k-th 32-bit word counted from the most
  // significant end of the block, byte-reversed.
  function automatic logic [31:0] exp_word(input logic [255:0] blk, input int words, input int k);
    logic [255:0] t;
    t = blk >> ((words - 1 - k) * 32);
    return bswap(t[31:0]);
  endfunction

  task automatic step(input logic bv, input logic [127:0] blk, input logic rr, input logic fl);
    logic exp_ready;
    @(negedge clk);
    block_valid = bv;
    block_in    = blk;
    rready      = rr;
    flush       = fl;
    #1;
    exp_ready = !fl && (q.size() == 0 || (q.size() == 1 && rr));
    check("rvalid", 64'(rvalid), 64'(q.size() > 0));
    check("busy", 64'(busy), 64'(q.size() > 0));
    check("rlast", 64'(rlast), 64'(q.size() == 1));
    check("block_ready", 64'(block_ready), 64'(exp_ready));
    check("rdata", 64'(rdata), 64'((q.size() > 0) ? q[0] : 32'h0));
    obs_rdata  = rdata;
    obs_ready  = block_ready;
    obs_rvalid = rvalid;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rr) void'(q.pop_front());
      if (bv && exp_ready) begin
        q.delete();
        for (int k = 0; k < 4; k++) q.push_back(exp_word({128'h0, blk}, 4, k));
      end
    end
  endtask

  initial begin
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [255:0] blk8;
    logic [31:0]  exp_seq [4];
    bit           bp [7];
    int           accepted;

    blk_a = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    blk_b = 128'hFFFFFFFF_00000000_12345678_9ABCDEF0;

    // Reset state
    #3;
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rlast", 64'(rlast), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_ready", 64'(block_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;

    // Basic readout
    exp_seq = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
    step(1'b1, blk_a, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("basic_w%0d", k), 64'(obs_rdata), 64'(exp_seq[k]));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("basic_idle", 64'(obs_rvalid), 64'd0);

    // Backpressure
    bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    step(1'b1, blk_a, 1'b0, 1'b0);
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, '0, bp[i], 1'b0);
      if (accepted < 3) check($sformatf("bp_ready%0d", i), 64'(obs_ready), 64'd0);
      if (bp[i]) begin
        check($sformatf("bp_word%0d", accepted), 64'(obs_rdata), 64'(exp_seq[accepted]));
        accepted++;
      end
    end
    check("bp_count", 64'(accepted), 64'd4);

    // Back-to-back
    step(1'b1, blk_a, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, blk_b, 1'b1, 1'b0);
    check("b2b_capture", 64'(obs_ready), 64'd1);
    exp_seq = '{32'hFFFFFFFF, 32'h00000000, 32'h78563412, 32'hF0DEBC9A};
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      check($sformatf("b2b_w%0d", k), 64'(obs_rdata), 64'(exp_seq[k]));
    end

    // Flush mid-block with a competing capture
    step(1'b1, blk_b, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, blk_a, 1'b1, 1'b1);
    check("flush_ready", 64'(obs_ready), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("flush_rvalid", 64'(obs_rvalid), 64'd0);
    check("flush_ready_after", 64'(obs_ready), 64'd1);

    // Asynchronous reset mid-drain
    step(1'b1, blk_a, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    block_valid = 1'b0;
    rready      = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_rvalid", 64'(rvalid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_rdata", 64'(rdata), 64'd0);
    check("arst_ready", 64'(block_ready), 64'd1);
    q.delete();
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 2) == 0),
           {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
    end
    step(1'b0, '0, 1'b0, 1'b1);

    // WORDS=8 sweep
    for (int rep = 0; rep < 2; rep++) begin
      blk8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      s8_block_in = blk8;
      s8_valid    = 1'b1;
      #1;
      check("w8_ready", 64'(s8_ready), 64'd1);
      @(negedge clk);
      s8_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (k > 0) @(negedge clk);
        #1;
        check($sformatf("w8_rvalid%0d", k), 64'(s8_rvalid), 64'd1);
        check($sformatf("w8_busy%0d", k), 64'(s8_busy), 64'd1);
        check($sformatf("w8_word%0d", k), 64'(s8_rdata), 64'(exp_word(blk8, 8, k)));
        check($sformatf("w8_rlast%0d", k), 64'(s8_rlast), 64'(k == 7));
      end
      @(negedge clk);
      #1;
      check("w8_idle", 64'(s8_rvalid), 64'd0);
    end

    // WORDS=1 sweep
    for (int rep = 0; rep < 3; rep++) begin
      @(negedge clk);
      s1_block_in = $urandom;
      s1_valid    = 1'b1;
      #1;
      check("w1_ready", 64'(s1_ready), 64'd1);
      @(negedge clk);
      s1_valid = 1'b0;
      #1;
      check("w1_word", 64'(s1_rdata), 64'(bswap(s1_block_in)));
      check("w1_rlast", 64'(s1_rlast), 64'd1);
      check("w1_busy", 64'(s1_busy), 64'd1);
      @(negedge clk);
      #1;
      check("w1_idle", 64'(s1_rvalid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
